// File: rtl/ntt_ctrl.sv
// Kyber NTT sequencer: walks 7 layers x 128 butterflies and delays write-back addresses by RD_LAT+BF_LAT.
// Define NTT_INVERSE_EN to honour `inv` and build the inverse (GS) address/zeta schedule.
module ntt_ctrl #(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inv,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] zeta_addr,
  output logic       bf_valid,
  output logic       bf_inv,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b,
  output logic [2:0] layer,
  output logic [1:0] dbg_state
);

  localparam int D = RD_LAT + BF_LAT;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t     state_q;
  logic [6:0] i_q;
  logic [2:0] layer_q;
  logic [2:0] dcnt_q;
  logic       inv_q;
  logic       inv_sel;

`ifdef NTT_INVERSE_EN
  assign inv_sel = inv;
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign inv_sel    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      layer_q <= '0;
      dcnt_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ISSUE;
            i_q     <= '0;
            layer_q <= '0;
            inv_q   <= inv_sel;
          end
        end
        S_ISSUE: begin
          i_q <= i_q + 7'd1;
          if (i_q == 7'd127) begin
            state_q <= S_DRAIN;
            dcnt_q  <= '0;
          end
        end
        S_DRAIN: begin
          // Leave only once the last write of this layer has landed.
          if (dcnt_q == 3'(D - 1)) begin
            if (layer_q == 3'd6) begin
              state_q <= S_DONE;
            end else begin
              layer_q <= layer_q + 3'd1;
              state_q <= S_ISSUE;
            end
          end else begin
            dcnt_q <= dcnt_q + 3'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [3:0] s;
  logic [7:0] idx, len, grp, addr_a, addr_b;
  logic [6:0] zeta;

  always_comb begin
    idx = {1'b0, i_q};
`ifdef NTT_INVERSE_EN
    if (inv_q) s = {1'b0, layer_q} + 4'd1;
    else       s = 4'd7 - {1'b0, layer_q};
`else
    s = 4'd7 - {1'b0, layer_q};
`endif
    len    = 8'd1 << s;
    grp    = idx >> s;
    addr_a = (grp << (s + 4'd1)) | (idx & (len - 8'd1));
    addr_b = addr_a + len;
    zeta   = 7'((8'd1 << layer_q) + grp);
`ifdef NTT_INVERSE_EN
    if (inv_q) zeta = 7'((8'd128 >> layer_q) - 8'd1 - grp);
`endif
  end

  assign rd_en     = (state_q == S_ISSUE);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign rd_addr_a = rd_en ? addr_a : '0;
  assign rd_addr_b = rd_en ? addr_b : '0;
  assign zeta_addr = rd_en ? zeta : '0;
  assign bf_inv    = inv_q;
  assign layer     = layer_q;
  assign dbg_state = state_q;

  // Issue-cycle {valid, addr_a, addr_b} delayed D cycles; tap RD_LAT-1 gives bf_valid.
  logic       dl_v_q [D];
  logic [7:0] dl_a_q [D];
  logic [7:0] dl_b_q [D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        dl_v_q[k] <= 1'b0;
        dl_a_q[k] <= '0;
        dl_b_q[k] <= '0;
      end
    end else begin
      dl_v_q[0] <= rd_en;
      dl_a_q[0] <= rd_addr_a;
      dl_b_q[0] <= rd_addr_b;
      for (int k = 1; k < D; k++) begin
        dl_v_q[k] <= dl_v_q[k-1];
        dl_a_q[k] <= dl_a_q[k-1];
        dl_b_q[k] <= dl_b_q[k-1];
      end
    end
  end

  assign bf_valid  = dl_v_q[RD_LAT-1];
  assign wr_en     = dl_v_q[D-1];
  assign wr_addr_a = dl_a_q[D-1];
  assign wr_addr_b = dl_b_q[D-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: default instance (RD_LAT=1, BF_LAT=2) and a deep instance (RD_LAT=2, BF_LAT=4).
module tb_ntt_ctrl;

`ifdef NTT_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic inv = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic       a_busy, a_done, a_rd_en, a_bf_valid, a_bf_inv, a_wr_en;
  logic [7:0] a_rd_addr_a, a_rd_addr_b, a_wr_addr_a, a_wr_addr_b;
  logic [6:0] a_zeta_addr;
  logic [2:0] a_layer;
  logic [1:0] a_dbg_state;
  logic       b_busy, b_done, b_rd_en, b_bf_valid, b_bf_inv, b_wr_en;
  logic [7:0] b_rd_addr_a, b_rd_addr_b, b_wr_addr_a, b_wr_addr_b;
  logic [6:0] b_zeta_addr;
  logic [2:0] b_layer;
  logic [1:0] b_dbg_state;

  ntt_ctrl #(.RD_LAT(1), .BF_LAT(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .inv(inv),
    .busy(a_busy), .done(a_done), .rd_en(a_rd_en),
    .rd_addr_a(a_rd_addr_a), .rd_addr_b(a_rd_addr_b), .zeta_addr(a_zeta_addr),
    .bf_valid(a_bf_valid), .bf_inv(a_bf_inv), .wr_en(a_wr_en),
    .wr_addr_a(a_wr_addr_a), .wr_addr_b(a_wr_addr_b), .layer(a_layer),
    .dbg_state(a_dbg_state)
  );

  ntt_ctrl #(.RD_LAT(2), .BF_LAT(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .inv(inv),
    .busy(b_busy), .done(b_done), .rd_en(b_rd_en),
    .rd_addr_a(b_rd_addr_a), .rd_addr_b(b_rd_addr_b), .zeta_addr(b_zeta_addr),
    .bf_valid(b_bf_valid), .bf_inv(b_bf_inv), .wr_en(b_wr_en),
    .wr_addr_a(b_wr_addr_a), .wr_addr_b(b_wr_addr_b), .layer(b_layer),
    .dbg_state(b_dbg_state)
  );

  logic [47:0] a_all, b_all, s_all;
  assign a_all = {a_busy, a_done, a_rd_en, a_rd_addr_a, a_rd_addr_b, a_zeta_addr,
                  a_bf_valid, a_bf_inv, a_wr_en, a_wr_addr_a, a_wr_addr_b, a_layer};
  assign b_all = {b_busy, b_done, b_rd_en, b_rd_addr_a, b_rd_addr_b, b_zeta_addr,
                  b_bf_valid, b_bf_inv, b_wr_en, b_wr_addr_a, b_wr_addr_b, b_layer};
  assign s_all = sel ? b_all : a_all;

  logic       s_busy, s_done, s_rd_en, s_bf_valid, s_bf_inv, s_wr_en;
  logic [7:0] s_rd_addr_a, s_rd_addr_b, s_wr_addr_a, s_wr_addr_b;
  logic [6:0] s_zeta_addr;
  logic [2:0] s_layer;
  assign {s_busy, s_done, s_rd_en, s_rd_addr_a, s_rd_addr_b, s_zeta_addr,
          s_bf_valid, s_bf_inv, s_wr_en, s_wr_addr_a, s_wr_addr_b, s_layer} = s_all;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit inv;
    int l;
    int i;
    int a;
    int b;
    int z;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // One complete transform on the selected instance, with per-cycle scoreboarding.
  task automatic run_xform(input bit inv_v, input int d, input int rdlat, input bit perturb);
    logic [31:0] exp_q[$];
    int          bf_q[$];
    logic [31:0] e;
    int rd_cnt = 0, wr_cnt = 0, bf_cnt = 0, done_cnt = 0, done_rel = -1;
    int busy_err = 0, sched_err = 0;
    int li, ii, due;
    bit eff_inv, exp_busy;
    eff_inv = inv_v & INV_EN;
    inv = inv_v;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int rel = 1; rel < 1300; rel++) begin
      if (rel == 1) check("bf_inv_mode", s_bf_inv, eff_inv);
      if (s_rd_en) begin
        li = rd_cnt / 128;
        ii = rd_cnt % 128;
        if (rel != 1 + li * (128 + d) + ii) sched_err++;
        foreach (vecs[v]) begin
          if (vecs[v].inv == eff_inv && vecs[v].l == li && vecs[v].i == ii) begin
            check("rd_addr_a", s_rd_addr_a, vecs[v].a);
            check("rd_addr_b", s_rd_addr_b, vecs[v].b);
            check("zeta_addr", s_zeta_addr, vecs[v].z);
          end
        end
        if (ii == 0) check("layer_status", s_layer, li);
        exp_q.push_back({16'(rel + d), s_rd_addr_a, s_rd_addr_b});
        bf_q.push_back(rel + rdlat);
        rd_cnt++;
      end
      if (s_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_cycle", rel, e[31:16]);
          check("wr_addrs", {s_wr_addr_a, s_wr_addr_b}, e[15:0]);
        end
      end
      if (s_bf_valid) begin
        bf_cnt++;
        if (bf_q.size() == 0) check("bf_unexpected", 1, 0);
        else begin
          due = bf_q.pop_front();
          check("bf_valid_cycle", rel, due);
        end
      end
      exp_busy = (rel >= 1) && (rel <= 7 * (128 + d));
      if (s_busy != exp_busy) busy_err++;
      if (s_done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (perturb && rel == 50) begin
        inv = ~inv_v;
        set_start(1'b1);
      end
      if (perturb && s_done) set_start(1'b1);
      if (done_rel > 0 && rel >= done_rel + 6) break;
      tick();
      set_start(1'b0);
      inv = inv_v;
    end
    check("done_cycle", done_rel, 7 * (128 + d) + 1);
    check("done_count", done_cnt, 1);
    check("rd_count", rd_cnt, 896);
    check("wr_count", wr_cnt, 896);
    check("bf_count", bf_cnt, 896);
    check("wr_queue_left", exp_q.size(), 0);
    check("busy_errors", busy_err, 0);
    check("schedule_errors", sched_err, 0);
  endtask

  // Reset asserted at layer 3, i=40; then the block must stay quiet.
  task automatic abort_run();
    int rd_cnt = 0, quiet_err = 0;
    bit found = 1'b0;
    inv = 1'b0;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int rel = 1; rel < 1000; rel++) begin
      if (s_rd_en) begin
        if (rd_cnt == 3 * 128 + 40) begin
          found = 1'b1;
          break;
        end
        rd_cnt++;
      end
      tick();
    end
    check("abort_reached", found, 1);
    check("abort_layer", s_layer, 3);
    rst = 1'b1;
    #1;
    check("async_rst_outputs", s_all, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (s_wr_en || s_rd_en || s_busy || s_done || s_bf_valid) quiet_err++;
      tick();
    end
    check("post_rst_quiet", quiet_err, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 0, 0,   0,   128, 1};
    vecs[1]  = '{1'b0, 0, 127, 127, 255, 1};
    vecs[2]  = '{1'b0, 1, 0,   0,   64,  2};
    vecs[3]  = '{1'b0, 1, 70,  134, 198, 3};
    vecs[4]  = '{1'b0, 3, 40,  72,  88,  10};
    vecs[5]  = '{1'b0, 6, 5,   9,   11,  66};
    vecs[6]  = '{1'b0, 6, 127, 253, 255, 127};
    vecs[7]  = '{1'b1, 0, 0,   0,   2,   127};
    vecs[8]  = '{1'b1, 0, 127, 253, 255, 64};
    vecs[9]  = '{1'b1, 2, 9,   17,  25,  30};
    vecs[10] = '{1'b1, 6, 0,   0,   128, 1};
    vecs[11] = '{1'b1, 6, 127, 127, 255, 1};

    rst = 1'b1;
    tick();
    tick();
    check("reset_outputs_a", a_all, 0);
    check("reset_outputs_b", b_all, 0);
    rst = 1'b0;
    tick();
    tick();

    sel = 1'b0;
    run_xform(1'b0, 3, 1, 1'b0);
    tick();
    run_xform(1'b1, 3, 1, 1'b1);
    tick();
    abort_run();
    run_xform(1'b0, 3, 1, 1'b0);
    tick();
    sel = 1'b1;
    #1;
    run_xform(1'b0, 6, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
